// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard.
// It runs the request-to-send sequence, shifts the frame on device clocks,
// checks the device ACK, and then returns the bus to idle.
// The oe outputs are open-drain pull-downs (1 = drive the line low).
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 12000,
   parameter int unsigned START_TIMEOUT  = 1500000,
   parameter int unsigned XFER_TIMEOUT   = 200000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_ack_err,
   output logic       tx_timeout,
   output logic       busy,
   output logic       rx_inhibit,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned CNT_MAX =
      (INHIBIT_CYCLES > START_TIMEOUT)
         ? ((INHIBIT_CYCLES > XFER_TIMEOUT) ? INHIBIT_CYCLES : XFER_TIMEOUT)
         : ((START_TIMEOUT  > XFER_TIMEOUT) ? START_TIMEOUT  : XFER_TIMEOUT);
   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQ       = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_filt_q, clk_filt_d;
   logic          data_filt_q, data_filt_d;
   logic [FW-1:0] clk_fcnt_q, clk_fcnt_d;
   logic [FW-1:0] data_fcnt_q, data_fcnt_d;
   logic          clk_filt_prev_q;
   logic          fall_q;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    frame_q, frame_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          ack_err_q, ack_err_d;
   logic          done_q, done_d;
   logic          ack_err_p_q, ack_err_p_d;
   logic          timeout_q, timeout_d;

   // Two-flop synchronizers; lines idle high, so reset to 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
      end
   end

   // Glitch filter: take the new level after FILTER_LEN consecutive differing cycles.
   always_comb begin
      clk_filt_d  = clk_filt_q;
      clk_fcnt_d  = '0;
      data_filt_d = data_filt_q;
      data_fcnt_d = '0;
      if (clk_sync_q[1] != clk_filt_q) begin
         if (clk_fcnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
         else                                   clk_fcnt_d = clk_fcnt_q + 1'b1;
      end
      if (data_sync_q[1] != data_filt_q) begin
         if (data_fcnt_q == FW'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
         else                                    data_fcnt_d = data_fcnt_q + 1'b1;
      end
   end

   // Filter state and the registered falling-edge strobe on filtered CLK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_filt_q      <= 1'b1;
         data_filt_q     <= 1'b1;
         clk_fcnt_q      <= '0;
         data_fcnt_q     <= '0;
         clk_filt_prev_q <= 1'b1;
         fall_q          <= 1'b0;
      end else begin
         clk_filt_q      <= clk_filt_d;
         data_filt_q     <= data_filt_d;
         clk_fcnt_q      <= clk_fcnt_d;
         data_fcnt_q     <= data_fcnt_d;
         clk_filt_prev_q <= clk_filt_q;
         fall_q          <= clk_filt_prev_q & ~clk_filt_q;
      end
   end

   // Transfer sequencer: next state, line drive, timers and result pulses.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      frame_d     = frame_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      ack_err_d   = ack_err_q;
      done_d      = 1'b0;
      ack_err_p_d = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               frame_d   = {1'b1, ~^tx_data, tx_data};
               bit_cnt_d = '0;
               cnt_d     = '0;
               ack_err_d = 1'b0;
               clk_oe_d  = 1'b1;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = S_REQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REQ: begin
            clk_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_SEND;
         end
         S_SEND: begin
            cnt_d = cnt_q + 1'b1;
            if (bit_cnt_q == 4'd0 && !fall_q && cnt_q == CW'(START_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               data_oe_d = 1'b0;
               state_d   = S_IDLE;
            end else if (cnt_q == CW'(XFER_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               data_oe_d = 1'b0;
               state_d   = S_IDLE;
            end else if (fall_q) begin
               data_oe_d = ~frame_q[bit_cnt_q];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9) state_d = S_ACK;
            end
         end
         S_ACK: begin
            cnt_d = cnt_q + 1'b1;
            if (fall_q) begin
               ack_err_d = data_filt_q;
               state_d   = S_WAIT_IDLE;
            end else if (cnt_q == CW'(XFER_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               data_oe_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_filt_q && data_filt_q) begin
               done_d      = ~ack_err_q;
               ack_err_p_d = ack_err_q;
               state_d     = S_IDLE;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset releases both lines immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         ack_err_q   <= 1'b0;
         done_q      <= 1'b0;
         ack_err_p_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_q     <= frame_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         ack_err_q   <= ack_err_d;
         done_q      <= done_d;
         ack_err_p_q <= ack_err_p_d;
         timeout_q   <= timeout_d;
      end
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign rx_inhibit  = busy;
   assign tx_done     = done_q;
   assign tx_ack_err  = ack_err_p_q;
   assign tx_timeout  = timeout_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule
